// File: rtl/perf_event_counter_bank_if.sv
// Bus bundle for the performance counter bank: event/control inputs and the registered read port.
interface perf_event_counter_bank_if #(
  parameter int NUM_CH = 6,
  parameter int CNT_W  = 32,
  parameter int SEL_W  = 4
);
  logic              enable;
  logic [NUM_CH-1:0] evt;
  logic              halt;
  logic              clear;
  logic              rd_req;
  logic [SEL_W-1:0]  rd_sel;
  logic              rd_valid;
  logic [CNT_W-1:0]  rd_data;
  logic [NUM_CH:0]   ovf;
  logic              halted;

  modport master (
    output enable, evt, halt, clear, rd_req, rd_sel,
    input  rd_valid, rd_data, ovf, halted
  );

  modport slave (
    input  enable, evt, halt, clear, rd_req, rd_sel,
    output rd_valid, rd_data, ovf, halted
  );
endinterface

// File: rtl/perf_event_counter_bank.sv
// Event counter bank plus free-running cycle counter; freezes on processor halt,
// sticky overflow flags, and a one-cycle-latency registered read port.
module perf_event_counter_bank #(
  parameter int NUM_CH   = 6,
  parameter int CNT_W    = 32,
  parameter bit SATURATE = 1'b0,
  parameter int SEL_W    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  perf_event_counter_bank_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {RUN, HALTED} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH+1];
  logic [CNT_W-1:0]  cnt_d [NUM_CH+1];
  logic [NUM_CH:0]   ovf_q, ovf_d;
  logic              rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0]  rd_data_q, rd_data_d;
  logic [CNT_W-1:0]  sel_val;
  logic [NUM_CH:0]   inc;

  // The top increment bit drives the cycle counter, which ticks every counted cycle.
  assign inc = {1'b1, bus.evt};

  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q;
    for (int i = 0; i <= NUM_CH; i++) cnt_d[i] = cnt_q[i];

    if (bus.clear) begin
      state_d = RUN;
      ovf_d   = '0;
      for (int i = 0; i <= NUM_CH; i++) cnt_d[i] = '0;
    end else if (state_q == RUN) begin
      if (bus.halt) state_d = HALTED;
      if (bus.enable) begin
        for (int i = 0; i <= NUM_CH; i++) begin
          if (inc[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
              ovf_d[i] = 1'b1;
              cnt_d[i] = SATURATE ? CNT_MAX : '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
        end
      end
    end
  end

  // Read mux looks at pre-update values, so a read coinciding with clear returns old data.
  always_comb begin
    sel_val = '0;
    for (int i = 0; i <= NUM_CH; i++) begin
      if (bus.rd_sel == SEL_W'(i)) sel_val = cnt_q[i];
    end
  end

  always_comb begin
    rd_valid_d = bus.rd_req;
    rd_data_d  = bus.rd_req ? sel_val : rd_data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      ovf_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      for (int i = 0; i <= NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      for (int i = 0; i <= NUM_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.ovf      = ovf_q;
  assign bus.halted   = (state_q == HALTED);

endmodule

// File: tb/tb_perf_event_counter_bank.sv
// Bench for perf_event_counter_bank: one default-sized bank and two 4-bit banks
// (wrap and saturate) share the same stimulus and are checked against one model.
module tb_perf_event_counter_bank;

  localparam int NCH = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  perf_event_counter_bank_if #(.NUM_CH(NCH), .CNT_W(32), .SEL_W(4)) m_if ();
  perf_event_counter_bank_if #(.NUM_CH(NCH), .CNT_W(4),  .SEL_W(4)) w_if ();
  perf_event_counter_bank_if #(.NUM_CH(NCH), .CNT_W(4),  .SEL_W(4)) s_if ();

  assign w_if.enable = m_if.enable;
  assign w_if.evt    = m_if.evt;
  assign w_if.halt   = m_if.halt;
  assign w_if.clear  = m_if.clear;
  assign w_if.rd_req = m_if.rd_req;
  assign w_if.rd_sel = m_if.rd_sel;
  assign s_if.enable = m_if.enable;
  assign s_if.evt    = m_if.evt;
  assign s_if.halt   = m_if.halt;
  assign s_if.clear  = m_if.clear;
  assign s_if.rd_req = m_if.rd_req;
  assign s_if.rd_sel = m_if.rd_sel;

  perf_event_counter_bank #(.NUM_CH(NCH), .CNT_W(32), .SATURATE(1'b0), .SEL_W(4))
    u_main (.clk(clk), .rst(rst), .bus(m_if));
  perf_event_counter_bank #(.NUM_CH(NCH), .CNT_W(4),  .SATURATE(1'b0), .SEL_W(4))
    u_wrap (.clk(clk), .rst(rst), .bus(w_if));
  perf_event_counter_bank #(.NUM_CH(NCH), .CNT_W(4),  .SATURATE(1'b1), .SEL_W(4))
    u_sat  (.clk(clk), .rst(rst), .bus(s_if));

  // Model state: index 0 = 32-bit wrap, 1 = 4-bit wrap, 2 = 4-bit saturate.
  longint    mc   [3][NCH+1];
  bit [NCH:0] mo  [3];
  longint    mrd  [3];
  longint    mx   [3];
  bit        msat [3];
  bit        mh;
  bit        mrv;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    for (int k = 0; k < 3; k++) begin
      mo[k]  = '0;
      mrd[k] = 0;
      for (int c = 0; c <= NCH; c++) mc[k][c] = 0;
    end
    mh  = 1'b0;
    mrv = 1'b0;
  endtask

  task automatic step_model();
    longint nv;
    int     sel;
    sel = int'(m_if.rd_sel);
    mrv = m_if.rd_req;
    for (int k = 0; k < 3; k++)
      if (m_if.rd_req) mrd[k] = (sel <= NCH) ? mc[k][sel] : 0;
    if (m_if.clear) begin
      for (int k = 0; k < 3; k++) begin
        mo[k] = '0;
        for (int c = 0; c <= NCH; c++) mc[k][c] = 0;
      end
      mh = 1'b0;
    end else if (!mh) begin
      if (m_if.enable) begin
        for (int k = 0; k < 3; k++) begin
          for (int c = 0; c <= NCH; c++) begin
            nv = mc[k][c] + ((c == NCH) ? 1 : longint'(m_if.evt[c]));
            if (nv > mx[k]) begin
              mo[k][c] = 1'b1;
              nv = msat[k] ? mx[k] : nv - (mx[k] + 1);
            end
            mc[k][c] = nv;
          end
        end
      end
      if (m_if.halt) mh = 1'b1;
    end
  endtask

  initial begin
    mx[0] = (longint'(1) << 32) - 1;  msat[0] = 1'b0;
    mx[1] = 15;                       msat[1] = 1'b0;
    mx[2] = 15;                       msat[2] = 1'b1;
    reset_model();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) reset_model();
      else      step_model();
    end
  end

  // Every-cycle comparison of all three banks against the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("m_rd_valid", longint'(m_if.rd_valid), longint'(mrv));
      chk("w_rd_valid", longint'(w_if.rd_valid), longint'(mrv));
      chk("s_rd_valid", longint'(s_if.rd_valid), longint'(mrv));
      chk("m_rd_data",  longint'(m_if.rd_data),  mrd[0]);
      chk("w_rd_data",  longint'(w_if.rd_data),  mrd[1]);
      chk("s_rd_data",  longint'(s_if.rd_data),  mrd[2]);
      chk("m_ovf",      longint'(m_if.ovf),      longint'(mo[0]));
      chk("w_ovf",      longint'(w_if.ovf),      longint'(mo[1]));
      chk("s_ovf",      longint'(s_if.ovf),      longint'(mo[2]));
      chk("m_halted",   longint'(m_if.halted),   longint'(mh));
      chk("w_halted",   longint'(w_if.halted),   longint'(mh));
      chk("s_halted",   longint'(s_if.halted),   longint'(mh));
    end
  end

  task automatic cyc(input bit en, input bit [NCH-1:0] ev, input bit hl,
                     input bit cl, input bit rq, input bit [3:0] sel);
    @(negedge clk);
    m_if.enable = en;
    m_if.evt    = ev;
    m_if.halt   = hl;
    m_if.clear  = cl;
    m_if.rd_req = rq;
    m_if.rd_sel = sel;
  endtask

  task automatic rd(input bit [3:0] sel, input longint exp, input string nm);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, sel);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0);
    chk({nm, "_valid"}, longint'(m_if.rd_valid), 1);
    chk(nm, longint'(m_if.rd_data), exp);
  endtask

  initial begin
    m_if.enable = 1'b0;
    m_if.evt    = '0;
    m_if.halt   = 1'b0;
    m_if.clear  = 1'b0;
    m_if.rd_req = 1'b0;
    m_if.rd_sel = '0;
    repeat (2) @(negedge clk);
    chk("rst_rd_valid", longint'(m_if.rd_valid), 0);
    chk("rst_rd_data",  longint'(m_if.rd_data),  0);
    chk("rst_ovf",      longint'(m_if.ovf),      0);
    chk("rst_halted",   longint'(m_if.halted),   0);
    rst = 1'b1;

    // Event 0 on 10 of 20 enabled cycles.
    for (int i = 0; i < 20; i++) cyc(1'b1, (i % 2 == 0) ? 6'b000001 : 6'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    rd(4'd0, 10, "t1_ch0");
    rd(4'd6, 20, "t1_cycle");
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("t1_valid_drop", longint'(m_if.rd_valid), 0);

    // Halt coinciding with the sixth event-2 pulse; channel 0 reaches 7.
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 4'd0);
    repeat (2) cyc(1'b1, 6'b000001, 1'b0, 1'b0, 1'b0, 4'd0);
    repeat (5) cyc(1'b1, 6'b000101, 1'b0, 1'b0, 1'b0, 4'd0);
    cyc(1'b1, 6'b000100, 1'b1, 1'b0, 1'b0, 4'd0);
    repeat (8) cyc(1'b1, 6'b111111, 1'b0, 1'b0, 1'b0, 4'd0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("t2_halted", longint'(m_if.halted), 1);
    rd(4'd2, 6, "t2_ch2");
    rd(4'd6, 8, "t2_cycle");

    // Clear from HALTED with a simultaneous read of channel 0.
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 4'd0);
    cyc(1'b1, 6'b000001, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("t4_valid",  longint'(m_if.rd_valid), 1);
    chk("t4_data",   longint'(m_if.rd_data),  7);
    chk("t4_halted", longint'(m_if.halted),   0);
    chk("t4_ovf",    longint'(m_if.ovf),      0);
    rd(4'd0, 1, "t4_ch0_resume");
    rd(4'd2, 0, "t4_ch2_cleared");
    rd(4'd6, 1, "t4_cycle_resume");

    // 17 channel-1 pulses: wrap vs saturate on the 4-bit banks.
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 4'd0);
    repeat (17) cyc(1'b1, 6'b000010, 1'b0, 1'b0, 1'b0, 4'd0);
    rd(4'd1, 17, "t3_main_ch1");
    chk("t3_wrap_ch1",  longint'(w_if.rd_data), 1);
    chk("t3_sat_ch1",   longint'(s_if.rd_data), 15);
    chk("t3_wrap_ovf1", longint'(w_if.ovf[1]),  1);
    chk("t3_sat_ovf1",  longint'(s_if.ovf[1]),  1);
    chk("t3_main_ovf1", longint'(m_if.ovf[1]),  0);

    // enable low with all events high; out-of-range select.
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 4'd0);
    repeat (3) cyc(1'b1, 6'b111111, 1'b0, 1'b0, 1'b0, 4'd0);
    repeat (4) cyc(1'b0, 6'b111111, 1'b0, 1'b0, 1'b0, 4'd0);
    rd(4'd0, 3, "t5_ch0");
    rd(4'd6, 3, "t5_cycle");
    rd(4'd7, 0, "t5_oob");
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("t5_halt_while_disabled", longint'(m_if.halted), 1);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 4'd0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("t5_clear_unhalts", longint'(m_if.halted), 0);

    // Asynchronous reset while a read is in flight.
    repeat (4) cyc(1'b1, 6'b000001, 1'b0, 1'b0, 1'b0, 4'd0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 4'd0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 4'd0);
    chk("t6_pre_valid", longint'(m_if.rd_valid), 1);
    chk("t6_pre_data",  longint'(m_if.rd_data),  4);
    #2;
    rst = 1'b0;
    m_if.rd_req = 1'b0;
    #1;
    chk("t6_async_valid", longint'(m_if.rd_valid), 0);
    chk("t6_async_data",  longint'(m_if.rd_data),  0);
    chk("t6_async_halted", longint'(m_if.halted),  0);
    @(negedge clk);
    rst = 1'b1;
    rd(4'd0, 0, "t6_ch0_after_rst");
    rd(4'd6, 0, "t6_cycle_no_enable");
    cyc(1'b1, '0, 1'b0, 1'b0, 1'b0, 4'd0);
    rd(4'd6, 1, "t6_cycle_enabled");

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
